nonce_uplink_tx: RTL and testbench
==================================

// Module: nonce_uplink_tx
// PURPOSE
// - Miner-side uplink transmitter: queues golden nonces from one miner and sends each as a 4-byte 8N1 UART word to the hub.
// - Mirror of the hub's slave_receive; one instance per miner, with TxD wired to the hub input port for that miner.
// - Nonces arriving faster than the line drains are buffered, not lost, up to DEPTH entries.
// PARAMETERS
// - CLK_HZ      50_000_000  hash_clk frequency in Hz
// - BAUD        115_200     line rate; BIT_TICKS = CLK_HZ/BAUD, integer division, must be >= 2
// - DEPTH_LOG2  3           FIFO holds 2**DEPTH_LOG2 nonces
// PORTS
// - clk         in   1             hash clock; the only clock
// - rst         in   1             asynchronous reset, active high
// - nonce       in   32            golden nonce; sampled when new_nonce=1
// - new_nonce   in   1             single-cycle strobe; one push per cycle when high
// - TxD         out  1             serial line; idles high
// - busy        out  1             high while a frame is on the line or the FIFO is non-empty
// - level       out  DEPTH_LOG2+1  current FIFO occupancy, 0..2**DEPTH_LOG2
// - overflow    out  1             sticky; set when a push is dropped; cleared only by rst
// BEHAVIOUR
// - Reset (async assert, sync release): TxD=1, busy=0, level=0, overflow=0, FIFO empty, FSM in IDLE, all counters 0.
// - Push: new_nonce=1 and FIFO not full -> write nonce, level+1 on the next edge.
// - Full: a push is dropped, the FIFO is unchanged, and overflow is set. If a pop happens in the same cycle, the push is accepted (level unchanged).
// - Simultaneous push+pop when not full: both happen; level unchanged.
// - FSM states: IDLE, START, DATA, STOP.
//   - IDLE: FIFO non-empty -> pop into a 32-bit shift word, byte_idx=0, go to START. Start of frame is 1 cycle after the edge where the FIFO becomes non-empty.
//   - START: TxD=0 for BIT_TICKS cycles -> DATA, bit_idx=0.
//   - DATA: TxD = current byte bit[bit_idx], LSB first, each bit held BIT_TICKS cycles. After bit 7 -> STOP.
//   - STOP: TxD=1 for BIT_TICKS cycles.
//     - If byte_idx<3: byte_idx+1, shift word right 8, go to START.
//     - Otherwise go to IDLE.
// - Byte order: nonce[7:0] first, nonce[31:24] last. No gap between bytes of one word beyond the single stop bit.
// - Back-to-back words: IDLE is left on the cycle after STOP completes if the FIFO is non-empty. Minimum inter-word gap is 1 cycle of idle high.
// - Frame length per word: 40*BIT_TICKS cycles (+1 IDLE cycle).
// - Tick counter: counts 0..BIT_TICKS-1 and wraps. bit_idx is 3 bits; byte_idx is 2 bits; neither counts beyond its terminal value.
// - A FIFO entry is popped only from IDLE; the head is never re-sent.
// - busy = (state != IDLE) || (level != 0), registered-output equivalent, with no combinational path from new_nonce.
// - rst mid-frame: TxD returns high asynchronously, the queued nonces are discarded, and the partial frame is abandoned. The hub resyncs on the next start bit.
// STRUCTURE
// - Shared package/header: UART_START_BIT=1'b0, UART_STOP_BIT=1'b1, UART_DATA_BITS=8, NONCE_BYTES=4, and the FSM state encodings.
//   - These are shared with slave_receive and serial_transmit so both ends agree on framing.
// - Sub-module nonce_fifo: synchronous single-clock FIFO.
//   - Width 32, depth 2**DEPTH_LOG2, async active-high reset.
//   - Ports: push/pop/din/dout/level/full/empty.
//   - Pointers are DEPTH_LOG2 bits and wrap; level is kept separately.
// - Top holds the FSM, tick/bit/byte counters, shift register and overflow flag.
// TESTING
// Sim params CLK_HZ=1000, BAUD=100 (BIT_TICKS=10); check against a bench UART receiver model.
// 1. Single nonce 32'hDEADBEEF strobed once after reset.
//    -> TxD low 2 cycles after the strobe edge.
//    -> Bytes EF,BE,AD,DE, each 0 start / 8 data LSB-first / 1 stop; 400 cycles total.
//    -> busy then falls; level returns to 0.
// 2. Eight strobes on consecutive cycles, nonces 1..8.
//    -> level reaches 8 with overflow=0.
//    -> All eight words are received in order with 1-cycle idle gaps.
// 3. Nine consecutive strobes into an empty FIFO while the line is idle.
//    -> The first pops at once; nonces 1..9 are all sent and overflow stays 0.
//    -> Repeat with the FIFO already full: the 9th is dropped, overflow=1 and stays 1 after the drain.
// 4. Strobe on the exact cycle IDLE pops while full.
//    -> Push accepted; level unchanged; no word lost or duplicated.
// 5. Assert rst during DATA of byte 2.
//    -> TxD=1 within the same cycle, level=0, overflow=0.
//    -> The next nonce after release is sent as a clean full frame.
// 6. No strobes for 1000 cycles after reset.
//    -> TxD constant 1, busy=0.

Source files
------------

// File: rtl/nonce_uplink_tx_pkg.sv
// Shared framing constants and FSM encoding for the nonce uplink (transmit side).
// Both ends of the link import these so that they agree on the frame format.
package nonce_uplink_tx_pkg;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam int   UART_DATA_BITS = 8;
  localparam int   NONCE_BYTES    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  function automatic int calc_bit_ticks(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/nonce_uplink_tx_fifo.sv
// Single-clock nonce FIFO: wrapping read/write pointers, occupancy kept in its own counter.
// When it is full, a push is accepted only if a pop happens in the same cycle.
module nonce_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  push_ok, pop_ok;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/nonce_uplink_tx.sv
// Miner-side uplink: buffers golden nonces and sends each one as four 8N1 bytes, LSB byte first.
// The line is driven from a register, so it trails the FSM state by one cycle and can never glitch.
module nonce_uplink_tx
  import nonce_uplink_tx_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         nonce,
  input  logic                new_nonce,
  output logic                TxD,
  output logic                busy,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow
);

  localparam int BIT_TICKS = calc_bit_ticks(CLK_HZ, BAUD);
  localparam int TICK_W    = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;

  tx_state_t         state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       shift_q, shift_d;
  logic              txd_q, txd_d;
  logic              overflow_q, overflow_d;

  logic              pop;
  logic [31:0]       fifo_dout;
  logic [DEPTH_LOG2:0] fifo_level;
  logic              fifo_full, fifo_empty;
  logic              tick_last;
  logic [7:0]        cur_byte;

  nonce_fifo #(
    .WIDTH      (32),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (new_nonce),
    .pop   (pop),
    .din   (nonce),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tick_last = (tick_q == TICK_W'(BIT_TICKS - 1));
  assign cur_byte  = shift_q[7:0];

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    txd_d      = UART_STOP_BIT;
    pop        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = fifo_dout;
          byte_idx_d = '0;
          bit_idx_d  = '0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        txd_d = UART_START_BIT;
        if (tick_last) begin
          tick_d    = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      ST_DATA: begin
        txd_d = cur_byte[bit_idx_q];
        if (tick_last) begin
          tick_d = '0;
          if (bit_idx_q == 3'(UART_DATA_BITS - 1)) state_d = ST_STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      ST_STOP: begin
        txd_d = UART_STOP_BIT;
        if (tick_last) begin
          tick_d = '0;
          // Next byte of the same word follows the stop bit with no extra gap.
          if (byte_idx_q != 2'(NONCE_BYTES - 1)) begin
            byte_idx_d = byte_idx_q + 2'd1;
            shift_d    = {8'h00, shift_q[31:8]};
            state_d    = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    overflow_d = overflow_q | (new_nonce && fifo_full && !pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      txd_q      <= UART_STOP_BIT;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      overflow_q <= overflow_d;
    end
  end

  assign TxD      = txd_q;
  assign overflow = overflow_q;
  assign level    = fifo_level;
  assign busy     = (state_q != ST_IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_nonce_uplink_tx.sv
// Bench for nonce_uplink_tx: time-based queue model plus a UART receiver that decodes TxD.
module tb_nonce_uplink_tx;

  localparam int BT       = 10;
  localparam int DL       = 3;
  localparam int DEPTH    = 8;
  localparam int WORD_CYC = 40 * BT;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   nonce;
  logic          new_nonce;
  logic          TxD;
  logic          busy;
  logic [DL:0]   level;
  logic          overflow;

  always #5 clk = ~clk;

  nonce_uplink_tx #(
    .CLK_HZ     (1000),
    .BAUD       (100),
    .DEPTH_LOG2 (DL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .nonce     (nonce),
    .new_nonce (new_nonce),
    .TxD       (TxD),
    .busy      (busy),
    .level     (level),
    .overflow  (overflow)
  );

  int checks = 0;
  int passed = 0;
  int failed = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: FIFO of capacity DEPTH; a word leaves the queue when the line
  // has been free for one cycle, and then occupies the transmitter for WORD_CYC cycles.
  logic [31:0] mq[$];
  logic [31:0] exp_q[$];
  int          me;
  int          next_ok;
  bit          m_ovf;
  bit          m_busy;

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    me      = 0;
    next_ok = 0;
    m_ovf   = 1'b0;
    m_busy  = 1'b0;
  endtask

  task automatic model_step(input bit p, input logic [31:0] v);
    bit do_pop;
    bit acc;
    do_pop = (me >= next_ok) && (mq.size() > 0);
    acc    = p && ((mq.size() < DEPTH) || do_pop);
    if (p && !acc) m_ovf = 1'b1;
    if (do_pop) begin
      exp_q.push_back(mq.pop_front());
      next_ok = me + WORD_CYC + 1;
    end
    if (acc) mq.push_back(v);
    m_busy = (mq.size() != 0) || (me + 1 < next_ok);
    me++;
  endtask

  // UART receiver model: samples TxD mid-bit on falling clock edges.
  logic [31:0] rx_q[$];
  int          rx_starts[$];
  int          rx_t = -1;
  int          rx_nb = 0;
  int          rx_j;
  int          rx_start_cyc = 0;
  int          frame_err = 0;
  logic [7:0]  rx_byte;
  logic [31:0] rx_word;

  initial begin
    rx_byte = '0;
    rx_word = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        rx_t  = -1;
        rx_nb = 0;
      end else if (rx_t < 0) begin
        if (TxD === 1'b0) begin
          rx_t = 0;
          if (rx_nb == 0) rx_start_cyc = cyc;
        end
      end else begin
        rx_t++;
        if (rx_t % BT == BT / 2) begin
          rx_j = rx_t / BT;
          if (rx_j == 0) begin
            if (TxD !== 1'b0) begin
              frame_err++;
              rx_t  = -1;
              rx_nb = 0;
            end
          end else if (rx_j <= 8) begin
            rx_byte[rx_j-1] = TxD;
          end else begin
            if (TxD !== 1'b1) frame_err++;
            rx_word[rx_nb*8 +: 8] = rx_byte;
            rx_nb++;
            rx_t = -1;
            if (rx_nb == 4) begin
              rx_q.push_back(rx_word);
              rx_starts.push_back(rx_start_cyc);
              $display("rx word %08h start cycle %0d", rx_word, rx_start_cyc);
              rx_nb = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock cycle: drive inputs, advance the model, compare at the falling edge.
  task automatic tick(input bit p, input logic [31:0] v);
    new_nonce = p;
    nonce     = v;
    model_step(p, v);
    @(posedge clk);
    @(negedge clk);
    new_nonce = 1'b0;
    check("level", 64'(level), 64'(mq.size()));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("busy", 64'(busy), 64'(m_busy));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    new_nonce = 1'b0;
    nonce     = '0;
    repeat (3) @(negedge clk);
    check("reset_txd", 64'(TxD), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_level", 64'(level), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    model_reset();
    rx_q.delete();
    rx_starts.delete();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((busy || mq.size() != 0) && n < 20000) begin
      tick(1'b0, '0);
      n++;
    end
    check({tag, "_drain_done"}, 64'(n < 20000), 64'd1);
    repeat (30) tick(1'b0, '0);
  endtask

  task automatic flush_cmp(input string tag);
    int n;
    check({tag, "_word_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_word"}, 64'(rx_q[i]), 64'(exp_q[i]));
    rx_q.delete();
    rx_starts.delete();
    exp_q.delete();
  endtask

  task automatic gap_cmp(input string tag);
    for (int i = 1; i < rx_starts.size(); i++)
      check({tag, "_gap"}, 64'(rx_starts[i] - rx_starts[i-1]), 64'(WORD_CYC + 1));
  endtask

  initial begin
    int n;
    int s;
    int bad;
    bit p;

    rst       = 1'b1;
    new_nonce = 1'b0;
    nonce     = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Quiet line after reset
    bad = 0;
    repeat (1000) begin
      tick(1'b0, '0);
      if (TxD !== 1'b1) bad++;
    end
    check("t6_txd_idle", 64'(bad), 64'd0);

    // Single nonce
    tick(1'b1, 32'hDEADBEEF);
    s = cyc;
    n = 0;
    while (busy && n < 600) begin
      tick(1'b0, '0);
      n++;
    end
    check("t1_busy_fall", 64'(n), 64'(WORD_CYC + 1));
    repeat (20) tick(1'b0, '0);
    check("t1_rx_count", 64'(rx_q.size()), 64'd1);
    if (rx_q.size() > 0) begin
      check("t1_word", 64'(rx_q[0]), 64'hDEADBEEF);
      check("t1_start_latency", 64'(rx_starts[0] - s), 64'd2);
    end
    flush_cmp("t1");

    // Eight queued behind a word in flight
    tick(1'b1, 32'h0000_0100);
    repeat (4) tick(1'b0, '0);
    for (int i = 1; i <= 8; i++) tick(1'b1, 32'(i));
    check("t2_level_full", 64'(level), 64'd8);
    check("t2_overflow", 64'(overflow), 64'd0);
    drain("t2");
    check("t2_rx_count", 64'(rx_q.size()), 64'd9);
    gap_cmp("t2");
    flush_cmp("t2");

    // Nine strobes into an empty, idle FIFO
    for (int i = 1; i <= 9; i++) tick(1'b1, 32'h300 + 32'(i));
    check("t3a_level", 64'(level), 64'd8);
    check("t3a_overflow", 64'(overflow), 64'd0);
    drain("t3a");
    check("t3a_rx_count", 64'(rx_q.size()), 64'd9);
    flush_cmp("t3a");

    // Push into an already full FIFO
    tick(1'b1, 32'h400);
    repeat (4) tick(1'b0, '0);
    for (int i = 1; i <= 9; i++) tick(1'b1, 32'h400 + 32'(i));
    check("t3b_overflow_set", 64'(overflow), 64'd1);
    drain("t3b");
    check("t3b_overflow_sticky", 64'(overflow), 64'd1);
    check("t3b_rx_count", 64'(rx_q.size()), 64'd9);
    flush_cmp("t3b");

    // Push on the exact cycle the idle FSM pops a full FIFO
    do_reset();
    tick(1'b1, 32'h500);
    repeat (4) tick(1'b0, '0);
    for (int i = 1; i <= 8; i++) tick(1'b1, 32'h500 + 32'(i));
    n = 0;
    while (me != next_ok && n < 1000) begin
      tick(1'b0, '0);
      n++;
    end
    check("t4_align", 64'(me), 64'(next_ok));
    tick(1'b1, 32'h509);
    check("t4_level", 64'(level), 64'd8);
    check("t4_overflow", 64'(overflow), 64'd0);
    drain("t4");
    check("t4_rx_count", 64'(rx_q.size()), 64'd10);
    flush_cmp("t4");

    // Reset in the middle of byte 2 (0x0D), while data bit 1 (a zero) is on the line
    do_reset();
    tick(1'b1, 32'h600DF00D);
    repeat (227) tick(1'b0, '0);
    check("t5_pre_txd", 64'(TxD), 64'd0);
    #1;
    rst = 1'b1;
    #1;
    check("t5_async_txd", 64'(TxD), 64'd1);
    check("t5_async_level", 64'(level), 64'd0);
    check("t5_async_overflow", 64'(overflow), 64'd0);
    do_reset();
    tick(1'b1, 32'hCAFEF00D);
    drain("t5");
    check("t5_rx_count", 64'(rx_q.size()), 64'd1);
    flush_cmp("t5");

    // Random strobes against the model
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      p = ($urandom_range(0, 99) < 2);
      tick(p, $urandom);
    end
    drain("rnd");
    flush_cmp("rnd");

    check("frame_errors", 64'(frame_err), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
